// File: rtl/bcd_scan_display.sv
// Multi-digit 7-segment scan controller: captures packed BCD on load and
// time-multiplexes digits onto a shared segment bus with per-slot blanking,
// optional leading-zero suppression and a frame tick.
// Optional decimal-point support is built when BCD_SCAN_DISPLAY_DP_EN is defined.
module bcd_scan_display #(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic                  blank_lz,
`ifdef BCD_SCAN_DISPLAY_DP_EN
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic                  seg_dp,
`endif
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_tick
);

  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW    = 4 * N_DIGITS;

  logic [DW-1:0]       shadow_q, shadow_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [6:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                tick_q, tick_d;
  logic [3:0]          digit_c;
  logic                higher_nz_c;
  logic                lz_blank_c;
`ifdef BCD_SCAN_DISPLAY_DP_EN
  logic [N_DIGITS-1:0] dp_q, dp_d;
  logic                seg_dp_q, seg_dp_d;
`endif

  // Segment pattern (a..g on bits 6..0) for one BCD digit; non-BCD codes are dark.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Next-state: shadow capture, slot counter/index, and registered display outputs.
  always_comb begin
    shadow_d    = shadow_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    seg_d       = seg_q;
    an_d        = '0;
    tick_d      = 1'b0;
    digit_c     = shadow_q[4*idx_q +: 4];
    higher_nz_c = 1'b0;
    lz_blank_c  = 1'b0;
`ifdef BCD_SCAN_DISPLAY_DP_EN
    dp_d        = dp_q;
    seg_dp_d    = seg_dp_q;
`endif

    if (load) begin
      shadow_d = digits;
`ifdef BCD_SCAN_DISPLAY_DP_EN
      dp_d     = dp_in;
`endif
    end

    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Any non-zero (including non-BCD) digit at or above the current one stops blanking.
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if ((i >= 32'(idx_q)) && (shadow_q[4*i +: 4] != 4'd0)) higher_nz_c = 1'b1;
    end
    lz_blank_c = blank_lz && (idx_q != '0) && !higher_nz_c;
`ifdef BCD_SCAN_DISPLAY_DP_EN
    if (dp_q[idx_q]) lz_blank_c = 1'b0;
`endif

    // Segment code is latched once per slot from the pre-edge shadow contents.
    if (cnt_q == '0) begin
      seg_d = lz_blank_c ? 7'b0000000 : bcd_to_seg(digit_c);
`ifdef BCD_SCAN_DISPLAY_DP_EN
      seg_dp_d = dp_q[idx_q];
`endif
    end

    // Enables and tick are computed from the next counter state so they line up with it.
    if (32'(cnt_d) >= BLANK_CYCLES) an_d = N_DIGITS'(1) << idx_d;
    tick_d = (idx_d == IDX_W'(N_DIGITS - 1)) && (cnt_d == CNT_W'(SCAN_DIV - 1));
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      seg_q    <= '0;
      an_q     <= '0;
      tick_q   <= 1'b0;
`ifdef BCD_SCAN_DISPLAY_DP_EN
      dp_q     <= '0;
      seg_dp_q <= 1'b0;
`endif
    end else begin
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      tick_q   <= tick_d;
`ifdef BCD_SCAN_DISPLAY_DP_EN
      dp_q     <= dp_d;
      seg_dp_q <= seg_dp_d;
`endif
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;
`ifdef BCD_SCAN_DISPLAY_DP_EN
  assign seg_dp     = seg_dp_q;
`endif

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display (N_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2).
module tb_bcd_scan_display;

  localparam int N  = 4;
  localparam int SD = 8;
  localparam int BL = 2;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S6 = 7'b1011111;
  localparam logic [6:0] S7 = 7'b1110000;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] S9 = 7'b1111011;
  localparam logic [6:0] SX = 7'b0000000;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] digits;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;
`ifdef BCD_SCAN_DISPLAY_DP_EN
  logic [3:0]  dp_in;
  logic        seg_dp;
`endif

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       tick;
    logic [1:0] idx;
    logic [2:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_chk;
  int          n_pass;
  int          m_cnt;
  int          m_idx;
  logic [15:0] m_shadow;
  logic [6:0]  m_seg;

  bcd_scan_display #(.N_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .digits     (digits),
    .blank_lz   (blank_lz),
`ifdef BCD_SCAN_DISPLAY_DP_EN
    .dp_in      (dp_in),
    .seg_dp     (seg_dp),
`endif
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1);
  end

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: return S0;
      4'd1: return S1;
      4'd2: return S2;
      4'd3: return S3;
      4'd4: return S4;
      4'd5: return S5;
      4'd6: return S6;
      4'd7: return S7;
      4'd8: return S8;
      4'd9: return S9;
      default: return SX;
    endcase
  endfunction

  function automatic logic [6:0] ref_digit(input logic [15:0] sh, input int idx, input logic lz);
    logic lead;
    lead = (idx > 0);
    for (int j = idx; j < N; j++) if (sh[4*j +: 4] != 4'd0) lead = 1'b0;
    return (lz && lead) ? SX : ref_seg(sh[4*idx +: 4]);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_shadow = '0; m_seg = '0;
  endtask

  // Advance one clock: update the reference model with pre-edge inputs and queue its expectation.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_cnt == 0) m_seg = ref_digit(m_shadow, m_idx, blank_lz);
      if (load) m_shadow = digits;
      if (m_cnt == SD - 1) begin
        m_cnt = 0;
        m_idx = (m_idx == N - 1) ? 0 : m_idx + 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    e.seg  = m_seg;
    e.an   = (!rst_n || m_cnt < BL) ? 4'b0000 : 4'(1 << m_idx);
    e.tick = rst_n && (m_idx == N - 1) && (m_cnt == SD - 1);
    e.idx  = 2'(m_idx);
    e.cnt  = 3'(m_cnt);
    sb.push_back(e);
    #1;
  endtask

  // Step until the model reaches the given slot/counter (expectations discarded).
  task automatic align(input int idx, input int cnt);
    exp_t e;
    int guard;
    guard = 0;
    while (!(m_idx == idx && m_cnt == cnt) && guard < 2 * N * SD) begin
      cycle();
      e = sb.pop_front();
      guard++;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    logic [3:0] an_lit;
    rst_n = 1'b0; load = 1'b0; digits = '0; blank_lz = 1'b0;
`ifdef BCD_SCAN_DISPLAY_DP_EN
    dp_in = '0;
`endif
    model_reset();
    #1;
    n_chk++;
    if ({seg, an, frame_tick} !== 12'h000)
      $display("FAIL reset_async seg=%b an=%b tick=%b required all zero", seg, an, frame_tick);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      cycle(); e = sb.pop_front();
      n_chk++;
      if ({seg, an, frame_tick} !== 12'h000)
        $display("FAIL reset_held cyc=%0d seg=%b an=%b tick=%b required all zero", k, seg, an, frame_tick);
      else n_pass++;
    end
    #2 rst_n = 1'b1;
    model_reset();
    for (int k = 1; k < 16; k++) begin
      cycle(); e = sb.pop_front();
      n_chk++;
      if (seg !== e.seg || an !== e.an || frame_tick !== e.tick)
        $display("FAIL reset_release k=%0d seg=%b an=%b tick=%b expected seg=%b an=%b tick=%b",
                 k, seg, an, frame_tick, e.seg, e.an, e.tick);
      else n_pass++;
      an_lit = ((k % SD) < BL) ? 4'b0000 : ((k < SD) ? 4'b0001 : 4'b0010);
      n_chk++;
      if (an !== an_lit) $display("FAIL reset_scan_an k=%0d an=%b expected %b", k, an, an_lit);
      else n_pass++;
    end
  endtask

  task automatic test_patterns();
    localparam int NC = 7;
    logic [15:0] pat [NC];
    logic        lzv [NC];
    logic [6:0]  lit [NC][4];
    exp_t        e;
    pat[0] = 16'h1234; lzv[0] = 1'b0; lit[0][0] = S4; lit[0][1] = S3; lit[0][2] = S2; lit[0][3] = S1;
    pat[1] = 16'h0050; lzv[1] = 1'b1; lit[1][0] = S0; lit[1][1] = S5; lit[1][2] = SX; lit[1][3] = SX;
    pat[2] = 16'h0050; lzv[2] = 1'b0; lit[2][0] = S0; lit[2][1] = S5; lit[2][2] = S0; lit[2][3] = S0;
    pat[3] = 16'hA9F0; lzv[3] = 1'b1; lit[3][0] = S0; lit[3][1] = SX; lit[3][2] = S9; lit[3][3] = SX;
    pat[4] = 16'h9876; lzv[4] = 1'b0; lit[4][0] = S6; lit[4][1] = S7; lit[4][2] = S8; lit[4][3] = S9;
    pat[5] = 16'h0000; lzv[5] = 1'b1; lit[5][0] = S0; lit[5][1] = SX; lit[5][2] = SX; lit[5][3] = SX;
    pat[6] = 16'hBCDE; lzv[6] = 1'b1; lit[6][0] = SX; lit[6][1] = SX; lit[6][2] = SX; lit[6][3] = SX;
    for (int c = 0; c < NC; c++) begin
      align(N - 1, SD - 1);
      digits = pat[c]; blank_lz = lzv[c]; load = 1'b1;
      for (int k = 0; k <= N * SD; k++) begin
        cycle(); load = 1'b0;
        e = sb.pop_front();
        n_chk++;
        if (seg !== e.seg || an !== e.an || frame_tick !== e.tick)
          $display("FAIL pattern case=%0d k=%0d seg=%b an=%b tick=%b expected seg=%b an=%b tick=%b",
                   c, k, seg, an, frame_tick, e.seg, e.an, e.tick);
        else n_pass++;
        if (e.cnt != 3'd0) begin
          n_chk++;
          if (seg !== lit[c][e.idx])
            $display("FAIL pattern_seg case=%0d slot=%0d cnt=%0d seg=%b expected %b",
                     c, e.idx, e.cnt, seg, lit[c][e.idx]);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_frame_tick();
    exp_t e;
    int first, second, count;
    first = -1; second = -1; count = 0;
    align(N - 1, SD - 1);
    for (int k = 0; k < 2 * N * SD; k++) begin
      cycle(); e = sb.pop_front();
      n_chk++;
      if (seg !== e.seg || an !== e.an || frame_tick !== e.tick)
        $display("FAIL frame_tick_cyc k=%0d seg=%b an=%b tick=%b expected seg=%b an=%b tick=%b",
                 k, seg, an, frame_tick, e.seg, e.an, e.tick);
      else n_pass++;
      if (frame_tick === 1'b1) begin
        if (count == 0) first = k; else if (count == 1) second = k;
        count++;
      end
    end
    n_chk++;
    if (count != 2 || first != N * SD - 1 || second != 2 * N * SD - 1)
      $display("FAIL frame_tick_period count=%0d first=%0d second=%0d expected 2 at %0d and %0d",
               count, first, second, N * SD - 1, 2 * N * SD - 1);
    else n_pass++;
  endtask

  task automatic test_midslot_load();
    exp_t e;
    logic wrapped;
    logic [6:0] lit;
    blank_lz = 1'b0;
    align(N - 1, SD - 1);
    digits = 16'h1234; load = 1'b1;
    cycle(); e = sb.pop_front(); load = 1'b0;
    align(1, 4);
    digits = 16'h5678; load = 1'b1;
    wrapped = 1'b0;
    for (int k = 0; k < 35; k++) begin
      cycle(); load = 1'b0;
      e = sb.pop_front();
      n_chk++;
      if (seg !== e.seg || an !== e.an || frame_tick !== e.tick)
        $display("FAIL midslot k=%0d seg=%b an=%b tick=%b expected seg=%b an=%b tick=%b",
                 k, seg, an, frame_tick, e.seg, e.an, e.tick);
      else n_pass++;
      if (e.idx == 2'd0) wrapped = 1'b1;
      case (e.idx)
        2'd0:    lit = S8;
        2'd1:    lit = wrapped ? S7 : S3;
        2'd2:    lit = S6;
        default: lit = S5;
      endcase
      if (e.cnt != 3'd0) begin
        n_chk++;
        if (seg !== lit)
          $display("FAIL midslot_seg k=%0d slot=%0d cnt=%0d seg=%b expected %b", k, e.idx, e.cnt, seg, lit);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    load = 1'b1;
    for (int k = 0; k < 3 * N * SD; k++) begin
      digits = 16'($urandom);
      if (k % (N * SD) == 0) blank_lz = 1'($urandom);
      cycle(); e = sb.pop_front();
      n_chk++;
      if (seg !== e.seg || an !== e.an || frame_tick !== e.tick)
        $display("FAIL back_to_back k=%0d seg=%b an=%b tick=%b expected seg=%b an=%b tick=%b",
                 k, seg, an, frame_tick, e.seg, e.an, e.tick);
      else n_pass++;
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    blank_lz = 1'b0;
    align(N - 1, SD - 1);
    digits = 16'h8888; load = 1'b1;
    cycle(); e = sb.pop_front(); load = 1'b0;
    align(2, 5);
    n_chk++;
    if (seg !== S8 || an !== 4'b0100)
      $display("FAIL reset_mid_pre seg=%b an=%b expected seg=%b an=0100", seg, an, S8);
    else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({seg, an, frame_tick} !== 12'h000)
      $display("FAIL reset_mid_async seg=%b an=%b tick=%b required all zero", seg, an, frame_tick);
    else n_pass++;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      cycle(); e = sb.pop_front();
      n_chk++;
      if ({seg, an, frame_tick} !== 12'h000)
        $display("FAIL reset_mid_held k=%0d seg=%b an=%b tick=%b required all zero", k, seg, an, frame_tick);
      else n_pass++;
    end
    #2 rst_n = 1'b1;
    model_reset();
    for (int k = 1; k < 12; k++) begin
      cycle(); e = sb.pop_front();
      n_chk++;
      if (seg !== e.seg || an !== e.an || frame_tick !== e.tick)
        $display("FAIL reset_mid_restart k=%0d seg=%b an=%b tick=%b expected seg=%b an=%b tick=%b",
                 k, seg, an, frame_tick, e.seg, e.an, e.tick);
      else n_pass++;
      if (k < SD) begin
        n_chk++;
        if (seg !== S0 || an !== ((k < BL) ? 4'b0000 : 4'b0001))
          $display("FAIL reset_mid_slot0 k=%0d seg=%b an=%b expected seg=%b an=%b",
                   k, seg, an, S0, (k < BL) ? 4'b0000 : 4'b0001);
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_patterns();
    test_frame_tick();
    test_midslot_load();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
